// File: rtl/matinv_pkg.sv
// Shared constants and types for the Gauss-Jordan inversion sequencer and
// the row-op datapath that decodes its commands.
package matinv_pkg;

    localparam int MAT_N    = 5;
    localparam int MAT_IDXW = 3;

    localparam logic [1:0] OP_NORM = 2'd0;
    localparam logic [1:0] OP_ELIM = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_NORM  = 3'd2,
        ST_NWAIT = 3'd3,
        ST_ELIM  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

endpackage

// File: rtl/matinv_row_iter.sv
// Row iterator: yields the next row index that skips the pivot row k.
// i_first selects the first such row; otherwise the row after i_cur.
// o_last is set when i_cur is the final non-pivot row.
module matinv_row_iter
    import matinv_pkg::*;
#(
    parameter int N    = MAT_N,
    parameter int IDXW = MAT_IDXW
) (
    input  logic [IDXW-1:0] i_k,
    input  logic [IDXW-1:0] i_cur,
    input  logic            i_first,
    output logic [IDXW-1:0] o_next,
    output logic            o_last
);

    logic [IDXW:0] w_base;
    logic [IDXW:0] w_cand;

    // Step past the pivot row; one extra bit detects running off the end
    always_comb begin
        w_base = i_first ? '0 : ({1'b0, i_cur} + (IDXW+1)'(1));
        w_cand = (w_base == {1'b0, i_k}) ? (w_base + (IDXW+1)'(1)) : w_base;
        o_next = w_cand[IDXW-1:0];
        o_last = (w_cand >= (IDXW+1)'(N));
    end

endmodule

// File: rtl/matinv_seq_ctrl.sv
// Gauss-Jordan inversion sequencer: per pivot, checks for a zero pivot,
// issues one NORM then N-1 back-to-back ELIMs to the external row-op unit,
// and drains outstanding ELIM completions before moving on.
module matinv_seq_ctrl
    import matinv_pkg::*;
#(
    parameter int N    = MAT_N,
    parameter int IDXW = MAT_IDXW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            singular,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [1:0]      op_code,
    output logic [IDXW-1:0] op_dst,
    output logic [IDXW-1:0] op_piv,
    input  logic            op_done,
    input  logic            piv_zero
);

    state_t          r_state;
    logic [IDXW-1:0] r_k;
    logic [IDXW-1:0] r_i;
    logic [IDXW:0]   r_cnt;
    logic            r_sing;

    logic            w_first;
    logic            w_hs;
    logic            w_inc;
    logic            w_dec;
    logic            w_drained;
    logic [IDXW-1:0] w_next;
    logic            w_last;

    matinv_row_iter #(
        .N    (N),
        .IDXW (IDXW)
    ) u_row_iter (
        .i_k     (r_k),
        .i_cur   (r_i),
        .i_first (w_first),
        .o_next  (w_next),
        .o_last  (w_last)
    );

    // Outputs decoded from state so reset clears them asynchronously
    always_comb begin
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_FIN);
        singular = r_sing;
        op_valid = (r_state == ST_NORM) || (r_state == ST_ELIM);
        op_code  = (r_state == ST_ELIM) ? OP_ELIM : OP_NORM;
        op_piv   = r_k;
        op_dst   = '0;
        if (r_state == ST_NORM) begin
            op_dst = r_k;
        end else if (r_state == ST_ELIM) begin
            op_dst = r_i;
        end
    end

    // Handshake and completion qualifiers; completions with nothing pending are dropped
    always_comb begin
        w_first   = (r_state == ST_NWAIT);
        w_hs      = op_valid && op_ready;
        w_inc     = (r_state == ST_ELIM) && w_hs;
        w_dec     = op_done && (r_cnt != '0) &&
                    ((r_state == ST_ELIM) || (r_state == ST_DRAIN));
        w_drained = (r_cnt == '0) || (w_dec && (r_cnt == (IDXW+1)'(1)));
    end

    // Outstanding ELIM counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + (IDXW+1)'(1);
        end else if (!w_inc && w_dec) begin
            r_cnt <= r_cnt - (IDXW+1)'(1);
        end
    end

    // Pivot sequencing FSM with pivot index, target row and singular flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_i     <= '0;
            r_sing  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_k     <= '0;
                        r_i     <= '0;
                        r_sing  <= 1'b0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (piv_zero) begin
                        r_sing  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (op_ready) begin
                        r_state <= ST_NWAIT;
                    end
                end
                ST_NWAIT: begin
                    if (op_done) begin
                        r_i     <= w_next;
                        r_state <= ST_ELIM;
                    end
                end
                ST_ELIM: begin
                    if (op_ready) begin
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_i <= w_next;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        if (r_k == IDXW'(N - 1)) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_k     <= r_k + IDXW'(1);
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matinv_seq_ctrl.sv
// Bench for matinv_seq_ctrl: a row-op unit model with programmable
// backpressure and completion latency, a command-list and timing reference
// derived from the pivot-walk rules, and directed plus randomized runs.
module tb_matinv_seq_ctrl;

    localparam int N    = 5;
    localparam int IDXW = 3;

    typedef struct packed {
        logic [1:0]      code;
        logic [IDXW-1:0] dst;
        logic [IDXW-1:0] piv;
    } cmd_t;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            start    = 1'b0;
    logic            op_ready = 1'b1;
    logic            op_done  = 1'b0;
    logic            piv_zero;
    logic            busy;
    logic            done;
    logic            singular;
    logic            op_valid;
    logic [1:0]      op_code;
    logic [IDXW-1:0] op_dst;
    logic [IDXW-1:0] op_piv;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int   stall_cycles = 0;
    int   lat          = 1;
    int   zero_piv     = -1;
    logic stray_req    = 1'b0;

    cmd_t acc_q[$];
    int   due_q[$];
    int   stall_cnt = 0;
    logic have_pend = 1'b0;
    cmd_t pend;

    matinv_seq_ctrl #(
        .N    (N),
        .IDXW (IDXW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .singular (singular),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_dst   (op_dst),
        .op_piv   (op_piv),
        .op_done  (op_done),
        .piv_zero (piv_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath status: a[k][k] is zero only for the chosen pivot
    assign piv_zero = (zero_piv >= 0) && (int'(op_piv) == zero_piv);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Row-op unit model: stalls each command, records accepts, returns op_done after lat cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            stall_cnt = 0;
            have_pend = 1'b0;
            op_ready  = 1'b1;
            op_done   = 1'b0;
        end else begin
            if (have_pend) begin
                chk("hold_valid", 32'(op_valid), 32'd1);
                chk("hold_cmd", 32'(cmd_t'({op_code, op_dst, op_piv})), 32'(pend));
            end
            op_ready = (stall_cnt >= stall_cycles);
            op_done  = stray_req;
            while (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                op_done = 1'b1;
            end
            if (op_valid) begin
                if (op_ready) begin
                    acc_q.push_back({op_code, op_dst, op_piv});
                    due_q.push_back(cyc + lat);
                    stall_cnt = 0;
                    have_pend = 1'b0;
                end else begin
                    stall_cnt++;
                    have_pend = 1'b1;
                    pend      = {op_code, op_dst, op_piv};
                end
            end
        end
    end

    // One inversion run from IDLE; called at a negedge, returns at a negedge in IDLE
    task automatic run(input int s, input int l, input int zp, input int extra_start, input string tag);
        cmd_t exp_q[$];
        int   per_piv;
        int   exp_done;
        int   got_done;
        int   c;
        int   nchk;
        stall_cycles = s;
        lat          = l;
        zero_piv     = zp;
        acc_q.delete();
        for (int k = 0; k < N; k++) begin
            if (k == zp) break;
            exp_q.push_back({2'd0, IDXW'(k), IDXW'(k)});
            for (int i = 0; i < N; i++)
                if (i != k) exp_q.push_back({2'd1, IDXW'(i), IDXW'(k)});
        end
        // CHECK + N commands of (1+s) cycles + NORM wait l + drain l
        per_piv  = 1 + (1 + s) * N + 2 * l;
        exp_done = (zp >= 0) ? (zp * per_piv + 2) : (N * per_piv + 1);
        got_done = -1;
        start = 1'b1;
        @(negedge clk);
        c = 1;
        chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
        chk({tag, "_sing_clr"}, 32'(singular), 32'd0);
        while (c <= 600) begin
            start = (c == extra_start);
            if (done) begin
                got_done = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({tag, "_done_cyc"}, 32'(got_done), 32'(exp_done));
        chk({tag, "_singular"}, 32'(singular), 32'(zp >= 0));
        chk({tag, "_ncmd"}, 32'(acc_q.size()), 32'(exp_q.size()));
        nchk = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int j = 0; j < nchk; j++)
            chk($sformatf("%s_cmd%0d", tag, j), 32'(acc_q[j]), 32'(exp_q[j]));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int found;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sing", 32'(singular), 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_fields", 32'({op_code, op_dst, op_piv}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 1, -1, -1, "best");
        run(3, 1, -1, -1, "bp");
        run(0, 1, 2, -1, "sing2");
        repeat (4) @(negedge clk);
        chk("sing_held", 32'(singular), 32'd1);
        run(0, 4, -1, -1, "late");
        run(0, 1, -1, 8, "start_busy");
        run(0, 1, 0, -1, "sing0");

        // Reset during ELIM of pivot 1
        stall_cycles = 0;
        lat          = 1;
        zero_piv     = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 100; t++) begin
            if (op_valid && op_code == 2'd1 && op_piv == IDXW'(1)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_found", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(op_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_fields", 32'({op_code, op_dst, op_piv, singular}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray_req = 1'b1;
        repeat (2) @(negedge clk);
        stray_req = 1'b0;
        @(negedge clk);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_valid", 32'(op_valid), 32'd0);
        run(0, 1, -1, -1, "after_rst");

        // Randomized stall, latency and zero-pivot position
        for (int r = 0; r < 4; r++) begin
            int s;
            int l;
            int z;
            s = $urandom_range(0, 2);
            l = $urandom_range(1, 5);
            z = $urandom_range(0, 9);
            if (z >= N) z = -1;
            run(s, l, z, -1, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
